// File: rtl/mem_stage_responder.sv
// Data-memory responder for the MEM stage: serves level-held read/write requests after WAIT_CYCLES wait states.
// Optional out-of-range detection with an addr_err pulse when MEM_RESP_BOUNDS_CHECK_EN is defined.
module mem_stage_responder #(
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] VAL_Rm,
  output logic [31:0] MEM_Res,
  output logic        ready
`ifdef MEM_RESP_BOUNDS_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             req;
  logic             finish;
  logic             wr_commit;
  logic             rd_commit;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             oob;
  logic             unused_bits;
  logic [31:0]      mem [DEPTH];

  assign req    = MEM_R_EN | MEM_W_EN;
  assign offset = ALU_Res - 32'(BASE_ADDR);
  assign idx    = offset[IDX_W+1:2];

`ifdef MEM_RESP_BOUNDS_CHECK_EN
  // DEPTH is a power of two, so any set bit above the index field means index >= DEPTH.
  assign oob = (ALU_Res < 32'(BASE_ADDR)) | (|offset[31:IDX_W+2]);
`else
  assign oob = 1'b0;
`endif

  assign unused_bits = ^{offset[1:0], offset[31:IDX_W+2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (req) state_nxt = BUSY;
      end
      BUSY: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A request that reads and writes at once behaves as a write only.
  always_comb begin
    ready     = (state == DONE) | ~req;
    finish    = (state == BUSY) & req & (cnt == CNT_LAST);
    wr_commit = finish & MEM_W_EN & ~oob & ~rst;
    rd_commit = finish & MEM_R_EN & ~MEM_W_EN;
  end

  always_ff @(posedge clk) begin
    if (wr_commit) mem[idx] <= VAL_Rm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_Res <= '0;
    end else if (rd_commit) begin
      MEM_Res <= oob ? 32'h0 : mem[idx];
    end
  end

`ifdef MEM_RESP_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else begin
      addr_err <= finish & oob;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_responder.sv
// Directed self-checking bench for mem_stage_responder (DEPTH=64, BASE_ADDR=1024, WAIT_CYCLES=5).
module tb_mem_stage_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en;
  logic        w_en;
  logic [31:0] alu;
  logic [31:0] val;
  logic [31:0] mem_res;
  logic        ready;
  logic        err_seen;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
  logic        addr_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_responder #(
    .DEPTH(64),
    .BASE_ADDR(1024),
    .WAIT_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .MEM_R_EN(r_en),
    .MEM_W_EN(w_en),
    .ALU_Res(alu),
    .VAL_Rm(val),
    .MEM_Res(mem_res),
    .ready(ready)
`ifdef MEM_RESP_BOUNDS_CHECK_EN
    ,
    .addr_err(addr_err)
`endif
  );

  // Entered just after a rising edge; the request is visible from cycle 0.
  // Returns the cycle in which ready rose (-1 on timeout) and MEM_Res seen then.
  task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, output int done_cyc,
                            output logic [31:0] res);
    int c;
    c = 0;
    r_en = r; w_en = w; alu = a; val = d;
    done_cyc = -1;
    res = 'x;
    err_seen = 1'bx;
    while (c < 40) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        done_cyc = c;
        res = mem_res;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
        err_seen = addr_err;
`endif
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    @(posedge clk); #1;
    r_en = 1'b0; w_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; r_en = 1'b0; w_en = 1'b0; alu = '0; val = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++;
    if (mem_res !== 32'h0) begin errors++; $display("FAIL reset_mem_res: got %h expected 00000000", mem_res); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int dc;
    logic [31:0] res;
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, dc, res);
    checks++;
    if (dc !== 6) begin errors++; $display("FAIL wr_latency: got %0d expected 6", dc); end
    checks++;
    if (res !== 32'h0) begin errors++; $display("FAIL wr_keeps_mem_res: got %h expected 00000000", res); end
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, dc, res);
    checks++;
    if (dc !== 6) begin errors++; $display("FAIL rd_latency: got %0d expected 6", dc); end
    checks++;
    if (res !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", res); end
  endtask

  task automatic test_back_to_back();
    int dc;
    logic [31:0] res;
    run_access(1'b0, 1'b1, 32'd1028, 32'h11111111, dc, res);
    checks++;
    if (dc !== 6) begin errors++; $display("FAIL b2b_wr_done: got %0d expected 6", dc); end
    run_access(1'b1, 1'b0, 32'd1028, 32'h0, dc, res);
    checks++;
    if (7 + dc !== 13) begin errors++; $display("FAIL b2b_rd_done: got %0d expected 13", 7 + dc); end
    checks++;
    if (res !== 32'h11111111) begin errors++; $display("FAIL b2b_rd_data: got %h expected 11111111", res); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_res !== 32'h11111111) begin errors++; $display("FAIL mem_res_hold: got %h expected 11111111", mem_res); end
    @(posedge clk); #1;
  endtask

  task automatic test_low_bits();
    int dc;
    logic [31:0] res;
    run_access(1'b1, 1'b0, 32'd1031, 32'h0, dc, res);
    checks++;
    if (res !== 32'h11111111 || dc !== 6) begin
      errors++; $display("FAIL low_bits: got %h at cycle %0d expected 11111111 at cycle 6", res, dc);
    end
  endtask

  task automatic test_abort();
    int dc;
    int lows;
    logic [31:0] res;
    run_access(1'b0, 1'b1, 32'd1032, 32'h12345678, dc, res);
    checks++;
    if (dc !== 6) begin errors++; $display("FAIL abort_prewrite: got %0d expected 6", dc); end
    lows = 0;
    r_en = 1'b0; w_en = 1'b1; alu = 32'd1032; val = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready === 1'b0) lows++;
      @(posedge clk); #1;
    end
    w_en = 1'b0;
    checks++;
    if (lows !== 3) begin errors++; $display("FAIL abort_ready_low: got %0d low cycles expected 3", lows); end
    @(negedge clk);
    checks++;
    if (mem_res !== 32'h11111111) begin errors++; $display("FAIL abort_mem_res: got %h expected 11111111", mem_res); end
    @(posedge clk); #1;
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, dc, res);
    checks++;
    if (dc !== 6) begin errors++; $display("FAIL abort_rd_latency: got %0d expected 6", dc); end
    checks++;
    if (res !== 32'h12345678) begin errors++; $display("FAIL abort_old_data: got %h expected 12345678", res); end
  endtask

  task automatic test_reset_mid();
    int dc;
    logic [31:0] res;
    run_access(1'b0, 1'b1, 32'd1036, 32'h0BADF00D, dc, res);
    run_access(1'b1, 1'b0, 32'd1036, 32'h0, dc, res);
    checks++;
    if (res !== 32'h0BADF00D) begin errors++; $display("FAIL rstmid_pre_read: got %h expected 0badf00d", res); end
    r_en = 1'b0; w_en = 1'b1; alu = 32'd1036; val = 32'h5;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; w_en = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_res !== 32'h0) begin errors++; $display("FAIL rstmid_mem_res: got %h expected 00000000", mem_res); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
    @(posedge clk); #1;
    run_access(1'b1, 1'b0, 32'd1036, 32'h0, dc, res);
    checks++;
    if (dc !== 6) begin errors++; $display("FAIL rstmid_rd_latency: got %0d expected 6", dc); end
    checks++;
    if (res !== 32'h0BADF00D) begin errors++; $display("FAIL rstmid_word_kept: got %h expected 0badf00d", res); end
  endtask

  task automatic test_both_en();
    int dc;
    logic [31:0] res;
    run_access(1'b1, 1'b1, 32'd1040, 32'h00000077, dc, res);
    checks++;
    if (res !== 32'h0BADF00D || dc !== 6) begin
      errors++; $display("FAIL both_en_mem_res: got %h at cycle %0d expected 0badf00d at cycle 6", res, dc);
    end
    run_access(1'b1, 1'b0, 32'd1040, 32'h0, dc, res);
    checks++;
    if (res !== 32'h00000077) begin errors++; $display("FAIL both_en_written: got %h expected 00000077", res); end
  endtask

  task automatic test_bounds();
    int dc;
    logic [31:0] res;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
    run_access(1'b1, 1'b0, 32'd1020, 32'h0, dc, res);
    checks++;
    if (res !== 32'h0 || err_seen !== 1'b1 || dc !== 6) begin
      errors++; $display("FAIL oob_low_read: got %h err %b cycle %0d expected 00000000 err 1 cycle 6", res, err_seen, dc);
    end
    run_access(1'b0, 1'b1, 32'd1280, 32'hFFFFFFFF, dc, res);
    checks++;
    if (err_seen !== 1'b1) begin errors++; $display("FAIL oob_write_err: got %b expected 1", err_seen); end
    run_access(1'b1, 1'b0, 32'd1280, 32'h0, dc, res);
    checks++;
    if (res !== 32'h0 || err_seen !== 1'b1) begin
      errors++; $display("FAIL oob_high_read: got %h err %b expected 00000000 err 1", res, err_seen);
    end
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, dc, res);
    checks++;
    if (res !== 32'hDEADBEEF || err_seen !== 1'b0) begin
      errors++; $display("FAIL inrange_after_oob: got %h err %b expected deadbeef err 0", res, err_seen);
    end
`else
    run_access(1'b1, 1'b0, 32'd1280, 32'h0, dc, res);
    checks++;
    if (res !== 32'hDEADBEEF || dc !== 6) begin
      errors++; $display("FAIL alias_word0: got %h at cycle %0d expected deadbeef at cycle 6", res, dc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_low_bits();
    test_abort();
    test_reset_mid();
    test_both_en();
    test_bounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
